// File: rtl/counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : counter_pkg                                                  |
// | Description : Shared definitions for the down_counter block: the FSM state |
// |               encoding and the default counter width.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package counter_pkg;

    localparam int unsigned C_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cnt_state_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : down_counter                                                 |
// | Description : Loadable down counter with terminal-count pulse, sticky      |
// |               done flag, optional auto-reload and abort.                   |
// | Ports       : clk          - clock, rising edge                            |
// |               reset        - synchronous, active-high reset                |
// |               load_valid   - request to load load_value                    |
// |               load_ready   - load can be accepted this cycle (comb.)       |
// |               load_value   - start value, captured on accepted load        |
// |               enable       - decrement qualifier while running             |
// |               auto_reload  - restart from stored value at terminal count   |
// |               abort        - cancel current run, highest priority          |
// |               count        - current counter value (registered)            |
// |               busy         - state is RUN                                  |
// |               tc           - one-cycle terminal-count pulse (registered)   |
// |               done         - sticky completion flag (registered)           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module down_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    cnt_state_e       state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q,     tc_d;
    logic             done_q,   done_d;

    logic             w_load_acc;

    assign load_ready = (state_q != ST_RUN) && !abort;
    assign w_load_acc = load_valid && load_ready;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        done_d   = done_q;

        if (abort) begin
            // Abort wins over load, decrement and reload, and swallows tc.
            state_d = ST_IDLE;
            count_d = '0;
            done_d  = 1'b0;
        end else if (w_load_acc) begin
            reload_d = load_value;
            count_d  = load_value;
            if (load_value != '0) begin
                state_d = ST_RUN;
                done_d  = 1'b0;
            end else begin
                // A zero load completes immediately; auto_reload does not apply.
                state_d = ST_DONE;
                tc_d    = 1'b1;
                done_d  = 1'b1;
            end
        end else if (state_q == ST_RUN) begin
            if (count_q == '0) begin
                // Only reachable for the single zero cycle of an auto-reload.
                count_d = reload_q;
            end else if (enable) begin
                count_d = count_q - WIDTH'(1);
                if (count_q == WIDTH'(1)) begin
                    tc_d = 1'b1;
                    if (!auto_reload) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == ST_RUN);
    assign tc    = tc_q;
    assign done  = done_q;

endmodule : down_counter
`default_nettype wire

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter: WIDTH, default 8, counter and load-value width in bits.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 load_valid  input  1  request to load a new start value.
REQ-005 load_ready  output  1  block can accept a load this cycle.
REQ-006 load_value  input  WIDTH  start value; captured on accepted load.
REQ-007 enable  input  1  decrement qualifier while running.
REQ-008 auto_reload  input  1  restart from the stored start value at terminal count.
REQ-009 abort  input  1  cancel current run.
REQ-010 count  output  WIDTH  current counter value, registered.
REQ-011 busy  output  1  high while state is RUN.
REQ-012 tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-013 done  output  1  sticky completion flag, registered.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 load_ready SHALL be combinational: (state != RUN) && !abort.
REQ-016 A load SHALL be accepted on a cycle with load_valid && load_ready; otherwise load_valid is ignored, including in RUN.
REQ-017 On an accepted load with load_value != 0: next cycle count = load_value, reload register = load_value, state = RUN, done = 0.
REQ-018 On an accepted load with load_value == 0: next cycle count = 0, tc = 1, state = DONE, done = 1; auto_reload is ignored.
REQ-019 In RUN with enable = 1 and abort = 0: count decrements by 1 per cycle; with enable = 0, count holds, with no added latency on resume.
REQ-020 When count == 1 is decremented, the next cycle SHALL show count = 0 and tc = 1; tc SHALL be 0 in every other cycle.
REQ-021 At that transition, if auto_reload = 1 (sampled in the decrementing cycle), the state stays RUN and the following cycle count = reload register; count shows 0 for exactly one cycle.
REQ-022 At that transition, if auto_reload = 0, the state becomes DONE with done = 1, held until the next accepted load, abort, or reset.
REQ-023 count SHALL never wrap below 0 or above load_value; no modular arithmetic is permitted.
REQ-024 abort SHALL have priority over load, decrement and reload.
REQ-025 On abort in any state: next cycle state = IDLE, count = 0, done = 0, tc = 0.
REQ-026 An abort coinciding with the terminal decrement SHALL suppress tc.
REQ-027 busy SHALL equal (state == RUN), decoded from the registered state.
REQ-028 A load accepted in DONE SHALL behave identically to a load accepted in IDLE.

Reset
REQ-029 While reset = 1 at a rising edge, the following SHALL be set: state = IDLE, count = 0, reload register = 0, tc = 0, done = 0.
REQ-030 reset SHALL override abort, load and decrement, including mid-run and in the same cycle as the terminal count.
REQ-031 load_ready SHALL be 1 in the first cycle after reset deasserts, provided abort = 0.

Structure
REQ-032 The state enumeration (IDLE, RUN, DONE) and the WIDTH default SHALL reside in the shared package counter_pkg.
REQ-033 The block SHALL be a single module with no sub-module; the FSM, counter and reload register are implemented inline.

Verification
REQ-034 Load 5, enable = 1, auto_reload = 0 -> count 5,4,3,2,1,0; tc high only at count 0; done = 1 and busy = 0 thereafter; load_ready = 1.
REQ-035 Load 3, auto_reload = 1, enable = 1 -> count 3,2,1,0,3,2,1,0; tc pulses each time count is 0; never enters DONE.
REQ-036 Load 4, enable toggled 1,0,0,1,1,1 -> count 4,3,3,3,2,1,0; tc one cycle at 0.
REQ-037 Load 2, then abort in the cycle count == 1 -> next cycle count = 0, tc = 0, done = 0, state IDLE.
REQ-038 load_value = 0 -> next cycle tc = 1 and done = 1; load_valid asserted during RUN of a load of 6 -> ignored, load_ready = 0.
REQ-039 Reset asserted mid-run at count = 7 of a load of 9 -> count = 0, done = 0, busy = 0, tc = 0 next cycle.
